// File: rtl/eq_gain_scheduler_pkg.sv
// Shared parameters, types and arithmetic helpers for the EQ gain scheduler.
package eq_pkg;

  localparam int NBAND    = 7;
  localparam int GAIN_W   = 16;
  localparam int GAIN_MAX = 12;
  localparam int GAIN_MIN = -12;
  localparam int BAND_W   = 3;
  localparam int OFS_W    = 3;

  typedef logic signed [GAIN_W-1:0] gain_t;
  typedef logic [BAND_W-1:0]        band_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_WRITE = 2'd2,
    S_CLEAR = 2'd3
  } state_t;

  // Saturate a requested gain into the legal gain window.
  function automatic gain_t eq_clamp(gain_t v);
    if (v > gain_t'(GAIN_MAX)) begin
      return gain_t'(GAIN_MAX);
    end else if (v < gain_t'(GAIN_MIN)) begin
      return gain_t'(GAIN_MIN);
    end else begin
      return v;
    end
  endfunction

  // One unit step from cur toward the clamped target; lands exactly on the
  // target when they are one apart and never overshoots it.
  function automatic gain_t eq_step(gain_t cur, gain_t target);
    gain_t t;
    t = eq_clamp(target);
    if (t > cur) begin
      return cur + gain_t'(1);
    end else if (t < cur) begin
      return cur - gain_t'(1);
    end else begin
      return cur;
    end
  endfunction

  // Next band index with wrap from NBAND-1 back to 0.
  function automatic band_t band_inc(band_t b);
    if (b == band_t'(NBAND - 1)) begin
      return '0;
    end else begin
      return b + band_t'(1);
    end
  endfunction

endpackage

// File: rtl/eq_gain_scheduler_if.sv
// Coefficient write port between the gain scheduler and the DSP core.
interface eq_gain_scheduler_if;
  import eq_pkg::*;

  logic  wr_valid;
  logic  wr_ready;
  band_t wr_band;
  gain_t wr_gain;

  // Scheduler side: offers a band/gain write and waits for ready.
  modport master (
    output wr_valid,
    output wr_band,
    output wr_gain,
    input  wr_ready
  );

  // DSP side: consumes the write when it raises ready.
  modport slave (
    input  wr_valid,
    input  wr_band,
    input  wr_gain,
    output wr_ready
  );

endinterface

// File: rtl/eq_gain_scheduler.sv
// Ramps per-band EQ gains toward the menu targets by one step per frame,
// issuing at most one coefficient write per frame, bands served round-robin.
module eq_gain_scheduler
  import eq_pkg::*;
(
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_frame,
  input  logic [NBAND-1:0][GAIN_W-1:0] i_target,
  input  logic [OFS_W-1:0]             i_offset,
  input  logic                         i_reset_req,
  eq_gain_scheduler_if.master          wr,
  output logic [OFS_W-1:0]             o_offset,
  output logic                         o_dsp_rst,
  output logic                         o_busy,
  output logic                         o_overrun
);

  state_t           state_q, state_d;
  band_t            idx_q, idx_d;       // band under examination
  band_t            cnt_q, cnt_d;       // bands examined so far this frame
  band_t            rr_q, rr_d;         // round-robin start band
  band_t            band_q, band_d;     // pending write band
  gain_t            gain_q, gain_d;     // pending write gain
  logic [OFS_W-1:0] offset_q, offset_d;
  logic             overrun_q, overrun_d;

  gain_t            cur_q [NBAND];      // gains already applied in the DSP
  logic             cur_we;
  logic             cur_clr;

  gain_t            target_w [NBAND];
  gain_t            t_scan;
  gain_t            cur_scan;

  // View the packed target bus as one signed gain per band.
  for (genvar gi = 0; gi < NBAND; gi++) begin : g_target
    assign target_w[gi] = gain_t'(i_target[gi]);
  end

  // The target is sampled at the moment its band is examined.
  assign t_scan   = eq_clamp(target_w[idx_q]);
  assign cur_scan = cur_q[idx_q];

  // Control and datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      rr_q      <= '0;
      band_q    <= '0;
      gain_q    <= '0;
      offset_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      rr_q      <= rr_d;
      band_q    <= band_d;
      gain_q    <= gain_d;
      offset_q  <= offset_d;
      overrun_q <= overrun_d;
    end
  end

  // Applied-gain storage: cleared as a whole, updated on a completed write.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < NBAND; b++) begin
      if (i_rst || cur_clr) begin
        cur_q[b] <= '0;
      end else if (cur_we && (band_q == band_t'(b))) begin
        cur_q[b] <= gain_q;
      end
    end
  end

  // Next-state logic: a clear request pre-empts everything, including a
  // write that is still waiting for the DSP.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    rr_d      = rr_q;
    band_d    = band_q;
    gain_d    = gain_q;
    offset_d  = offset_q;
    overrun_d = overrun_q;
    cur_we    = 1'b0;
    cur_clr   = 1'b0;

    // A frame arriving while we are still working is lost; a frame that
    // coincides with a clear request is discarded silently.
    if (i_frame && !i_reset_req && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end

    // The clear cycle wipes the applied state regardless of what follows.
    if (state_q == S_CLEAR) begin
      cur_clr  = 1'b1;
      offset_d = '0;
      rr_d     = '0;
    end

    if (i_reset_req) begin
      state_d = S_CLEAR;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_frame) begin
            offset_d = i_offset;
            idx_d    = rr_q;
            cnt_d    = '0;
            state_d  = S_SCAN;
          end
        end
        S_SCAN: begin
          if (t_scan != cur_scan) begin
            band_d  = idx_q;
            gain_d  = eq_step(cur_scan, t_scan);
            state_d = S_WRITE;
          end else begin
            idx_d = band_inc(idx_q);
            if (cnt_q == band_t'(NBAND - 1)) begin
              state_d = S_IDLE;
            end else begin
              cnt_d = cnt_q + band_t'(1);
            end
          end
        end
        S_WRITE: begin
          if (wr.wr_ready) begin
            cur_we  = 1'b1;
            rr_d    = band_inc(band_q);
            state_d = S_IDLE;
          end
        end
        S_CLEAR: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // All outputs come straight from registers; no combinational input path.
  assign wr.wr_valid = (state_q == S_WRITE);
  assign wr.wr_band  = band_q;
  assign wr.wr_gain  = gain_q;
  assign o_offset    = offset_q;
  assign o_dsp_rst   = (state_q == S_CLEAR);
  assign o_busy      = (state_q != S_IDLE);
  assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_eq_gain_scheduler.sv
// Directed bench for eq_gain_scheduler with a frame-level behavioural model.
module tb_eq_gain_scheduler;
  import eq_pkg::*;

  logic                         clk = 1'b0;
  logic                         rst = 1'b1;
  logic                         frame = 1'b0;
  logic [NBAND-1:0][GAIN_W-1:0] target = '0;
  logic [OFS_W-1:0]             offset_in = '0;
  logic                         reset_req = 1'b0;
  logic [OFS_W-1:0]             o_offset;
  logic                         o_dsp_rst;
  logic                         o_busy;
  logic                         o_overrun;

  eq_gain_scheduler_if ifc();

  eq_gain_scheduler dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_frame     (frame),
    .i_target    (target),
    .i_offset    (offset_in),
    .i_reset_req (reset_req),
    .wr          (ifc),
    .o_offset    (o_offset),
    .o_dsp_rst   (o_dsp_rst),
    .o_busy      (o_busy),
    .o_overrun   (o_overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cycle = 0;
  bit started = 1'b0;

  int wq_band[$];
  int wq_gain[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d want=%0d", name, cycle, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Abstract view: on an accepted frame the whole scan outcome is decided at
  // once (first band from rr whose clamped target differs from its applied
  // gain), and the model just counts down the visible busy time.
  int m_cur[NBAND];
  int m_rr = 0, m_off = 0;
  bit m_ovr = 0, m_wv = 0, m_clr = 0, m_wpend = 0;
  int m_scan = 0, m_band = 0, m_gain = 0, m_pband = 0, m_pgain = 0;
  bit m_busy_now;
  int m_b, m_t;
  bit m_found;

  function automatic int clampi(int v);
    if (v > GAIN_MAX) return GAIN_MAX;
    if (v < GAIN_MIN) return GAIN_MIN;
    return v;
  endfunction

  always @(posedge clk) begin
    cycle++;
    started = 1'b1;
    m_busy_now = (m_scan > 0) || m_wv || m_clr;
    if (rst) begin
      for (int i = 0; i < NBAND; i++) m_cur[i] = 0;
      m_rr = 0; m_off = 0; m_ovr = 0; m_wv = 0; m_clr = 0; m_wpend = 0;
      m_scan = 0; m_band = 0; m_gain = 0;
    end else begin
      if (frame && !reset_req && m_busy_now) m_ovr = 1;
      if (m_clr) begin
        for (int i = 0; i < NBAND; i++) m_cur[i] = 0;
        m_off = 0; m_rr = 0; m_clr = 0;
      end
      if (reset_req) begin
        m_clr = 1; m_scan = 0; m_wv = 0; m_wpend = 0;
      end else if (m_wv) begin
        if (ifc.wr_ready) begin
          m_cur[m_band] = m_gain;
          m_rr = (m_band + 1) % NBAND;
          m_wv = 0;
        end
      end else if (m_scan > 0) begin
        m_scan--;
        if (m_scan == 0 && m_wpend) begin
          m_wv = 1; m_band = m_pband; m_gain = m_pgain; m_wpend = 0;
        end
      end else if (!m_busy_now && frame) begin
        m_off = int'(offset_in);
        m_found = 0;
        for (int k = 0; k < NBAND; k++) begin
          if (!m_found) begin
            m_b = (m_rr + k) % NBAND;
            m_t = clampi(int'($signed(target[m_b])));
            if (m_t != m_cur[m_b]) begin
              m_found = 1;
              m_scan = k + 1;
              m_wpend = 1;
              m_pband = m_b;
              m_pgain = m_cur[m_b] + ((m_t > m_cur[m_b]) ? 1 : -1);
            end
          end
        end
        if (!m_found) begin
          m_scan = NBAND;
          m_wpend = 0;
        end
      end
    end
  end

  // Completed handshakes, one line each.
  always @(posedge clk) begin
    if (!rst && !reset_req && ifc.wr_valid && ifc.wr_ready) begin
      wq_band.push_back(int'(ifc.wr_band));
      wq_gain.push_back(int'($signed(ifc.wr_gain)));
      $display("write band=%0d gain=%0d cycle=%0d", ifc.wr_band, $signed(ifc.wr_gain), cycle);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("busy", int'(o_busy), int'((m_scan > 0) || m_wv || m_clr));
      chk("wr_valid", int'(ifc.wr_valid), int'(m_wv));
      chk("dsp_rst", int'(o_dsp_rst), int'(m_clr));
      chk("offset", int'(o_offset), m_off);
      chk("overrun", int'(o_overrun), int'(m_ovr));
      if (m_wv) begin
        chk("wr_band", int'(ifc.wr_band), m_band);
        chk("wr_gain", int'($signed(ifc.wr_gain)), m_gain);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    rst = 1'b1; frame = 1'b0; reset_req = 1'b0; target = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wq_band.delete();
    wq_gain.delete();
  endtask

  task automatic pulse_frame();
    frame = 1'b1;
    @(negedge clk);
    frame = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (o_busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) chk("idle_timeout", 1, 0);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!ifc.wr_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (n >= 20) chk("valid_timeout", 1, 0);
  endtask

  int n_busy;
  int gmax, gmin;
  int exp_b[$];
  int exp_g[$];

  initial begin
    ifc.wr_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset state pinned with literals.
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_valid", int'(ifc.wr_valid), 0);
    chk("rst_offset", int'(o_offset), 0);

    // Single band ramp 0 -> 3, then a quiet frame scanning all bands.
    do_reset();
    target[2] = 16'(3);
    ifc.wr_ready = 1'b1;
    for (int f = 0; f < 4; f++) begin
      pulse_frame();
      wait_idle(n_busy);
    end
    chk("t1_busy_cycles", n_busy, 7);
    chk("t1_nwrites", wq_band.size(), 3);
    for (int i = 0; i < 3 && i < wq_band.size(); i++) begin
      chk("t1_band", wq_band[i], 2);
      chk("t1_gain", wq_gain[i], i + 1);
    end

    // Round-robin between two bands.
    do_reset();
    target[1] = 16'(5);
    target[4] = 16'(-2);
    for (int f = 0; f < 8; f++) begin
      pulse_frame();
      wait_idle(n_busy);
    end
    exp_b = '{1, 4, 1, 4, 1, 1, 1};
    exp_g = '{1, -1, 2, -2, 3, 4, 5};
    chk("t2_nwrites", wq_band.size(), 7);
    for (int i = 0; i < 7 && i < wq_band.size(); i++) begin
      chk("t2_band", wq_band[i], exp_b[i]);
      chk("t2_gain", wq_gain[i], exp_g[i]);
    end

    // Clamping at both limits.
    do_reset();
    target[0] = 16'(40);
    for (int f = 0; f < 14; f++) begin
      pulse_frame();
      wait_idle(n_busy);
    end
    gmax = -1000;
    foreach (wq_gain[i]) if (wq_gain[i] > gmax) gmax = wq_gain[i];
    chk("t3_up_nwrites", wq_band.size(), 12);
    chk("t3_up_max", gmax, 12);
    chk("t3_model_hi", m_cur[0], 12);
    wq_band.delete();
    wq_gain.delete();
    target[0] = 16'(-40);
    for (int f = 0; f < 26; f++) begin
      pulse_frame();
      wait_idle(n_busy);
    end
    gmin = 1000;
    foreach (wq_gain[i]) if (wq_gain[i] < gmin) gmin = wq_gain[i];
    chk("t3_dn_nwrites", wq_band.size(), 24);
    chk("t3_dn_min", gmin, -12);
    chk("t3_model_lo", m_cur[0], -12);

    // Back-pressure with an overrun frame during the wait.
    do_reset();
    ifc.wr_ready = 1'b0;
    target[3] = 16'(2);
    pulse_frame();
    wait_valid();
    for (int i = 0; i < 20; i++) begin
      frame = (i == 5);
      @(negedge clk);
      chk("t4_hold_valid", int'(ifc.wr_valid), 1);
      chk("t4_hold_band", int'(ifc.wr_band), 3);
      chk("t4_hold_gain", int'($signed(ifc.wr_gain)), 1);
    end
    frame = 1'b0;
    chk("t4_overrun", int'(o_overrun), 1);
    ifc.wr_ready = 1'b1;
    @(negedge clk);
    ifc.wr_ready = 1'b0;
    chk("t4_nwrites", wq_band.size(), 1);
    chk("t4_valid_drop", int'(ifc.wr_valid), 0);

    // Clear request aborts a pending write.
    do_reset();
    ifc.wr_ready = 1'b0;
    target[5] = 16'(4);
    offset_in = 3'd5;
    pulse_frame();
    wait_valid();
    reset_req = 1'b1;
    @(negedge clk);
    reset_req = 1'b0;
    chk("t5_valid_drop", int'(ifc.wr_valid), 0);
    chk("t5_dsp_rst_hi", int'(o_dsp_rst), 1);
    @(negedge clk);
    chk("t5_dsp_rst_lo", int'(o_dsp_rst), 0);
    chk("t5_offset0", int'(o_offset), 0);
    ifc.wr_ready = 1'b1;
    pulse_frame();
    wait_idle(n_busy);
    chk("t5_nwrites", wq_band.size(), 1);
    if (wq_band.size() > 0) begin
      chk("t5_band", wq_band[0], 5);
      chk("t5_gain", wq_gain[0], 1);
    end

    // Offset latch timing and simultaneous clear + frame.
    do_reset();
    offset_in = 3'd3;
    pulse_frame();
    chk("t6_offset_t1", int'(o_offset), 3);
    wait_idle(n_busy);
    offset_in = 3'd6;
    frame = 1'b1;
    reset_req = 1'b1;
    @(negedge clk);
    frame = 1'b0;
    reset_req = 1'b0;
    chk("t6_dsp_rst", int'(o_dsp_rst), 1);
    @(negedge clk);
    chk("t6_offset0", int'(o_offset), 0);
    chk("t6_overrun0", int'(o_overrun), 0);
    chk("t6_idle", int'(o_busy), 0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
